missile_fire_sched: RTL
=======================

// Module: missile_fire_sched
// PURPOSE
//   Fire scheduler for the player ship's missile engines. Shares NUM_SLOTS missile
//   controllers between player fire requests. On each accepted request it picks the
//   lowest-index free slot, pulses that slot's fire input, confirms launch via the
//   slot's on flag, then enforces a cooldown. Sits between input handling and the
//   missile controller array.
// PARAMETERS
//   NUM_SLOTS        3        number of missile controllers managed (1..8)
//   COOLDOWN_CYCLES  2000000  pclk cycles between consecutive launches (>=1)
//   ACK_TIMEOUT      4        cycles to wait for slot_on[sel] after a fire pulse (>=3)
//   CNT_W            22       cooldown counter width; must hold COOLDOWN_CYCLES-1
// PORTS
//   pclk         in   1          pixel clock; all logic on posedge
//   rst          in   1          synchronous reset, active-high
//   fire_btn     in   1          fire button level, already synchronised to pclk
//   ship_dead    in   1          ship destroyed; aborts and blocks firing
//   slot_on      in   NUM_SLOTS  per-slot missile-in-flight flag from each controller
//   slot_fire    out  NUM_SLOTS  one-hot, one-cycle fire pulse to the selected slot
//   all_busy     out  1          registered &slot_on (no free slot)
//   cooldown     out  1          high while in COOLDOWN
//   shots_fired  out  16         confirmed launches, saturates at 16'hFFFF
//   ack_err      out  1          sticky: a fire pulse was not acknowledged in time
// BEHAVIOUR
//   Reset: state=IDLE; slot_fire=0; all_busy=0; cooldown=0; shots_fired=0; ack_err=0;
//     pending=0; btn_prev=0; sel=0; counters=0. All outputs are registered.
//   Request: rising edge (fire_btn & ~btn_prev) sets one-deep pending flag in any
//     state; extra edges while pending are dropped. pending clears on ISSUE entry.
//   FSM (2-bit): IDLE, ISSUE, WAIT_ACK, COOLDOWN.
//   IDLE: if pending & ~ship_dead & any ~slot_on -> ISSUE; sel <= lowest free index.
//     Pending is held (not dropped) while all slots are busy.
//   ISSUE: slot_fire <= onehot(sel) for exactly one cycle -> WAIT_ACK; ack counter=0.
//   WAIT_ACK: slot_on[sel]==1 -> COOLDOWN, shots_fired += 1 (saturating).
//     ack counter reaches ACK_TIMEOUT with no ack -> COOLDOWN, ack_err <= 1, no count.
//     A slot controller raises on 2 cycles after the pulse; nominal latency
//     edge-to-pulse = 2 cycles, pulse-to-COOLDOWN = 3 cycles.
//   COOLDOWN: counter loads COOLDOWN_CYCLES-1 on entry, decrements each cycle;
//     at 0 -> IDLE. cooldown output high for COOLDOWN_CYCLES cycles.
//   ship_dead (any state, highest priority): next state IDLE, slot_fire <= 0,
//     pending <= 0, counters <= 0; shots_fired and ack_err retained.
//   Simultaneous edge + ship_dead: edge discarded. Edge in same cycle pending is
//     cleared by ISSUE entry: new pending is set (next shot queued).
//   Reset mid-flight: all state cleared; slot controllers reset independently.
// CONFIGURATION
//   AUTOFIRE_EN defined: in IDLE, pending is also set whenever fire_btn is high
//     (level), so a held button fires every COOLDOWN_CYCLES+~5 cycles while a slot
//     is free. Not defined: edge-triggered only; holding fires exactly once.
// STRUCTURE
//   Package missile_pkg: FSM state encodings, default NUM_SLOTS, COOLDOWN_CYCLES,
//     ACK_TIMEOUT, shared missile geometry/height constants used by slot controllers.
//   Sub-module missile_slot_pick: combinational lowest-free-index encoder
//     (in: slot_on; out: sel index + any_free). Rest stays in this module.
// TESTING (bench: NUM_SLOTS=3, COOLDOWN_CYCLES=10, ACK_TIMEOUT=4, model slots ack 2 cycles after pulse)
//   1. slot_on=000, one fire_btn edge -> slot_fire=001 for 1 cycle 2 cycles later;
//      shots_fired=1; cooldown high exactly 10 cycles; back to IDLE.
//   2. slot_on=011, edge -> slot_fire=100; slot_on=111, edge -> no pulse, all_busy=1;
//      release slot 1 (slot_on=101) -> queued shot issues slot_fire=010.
//   3. Two edges during COOLDOWN -> exactly one extra launch after cooldown ends.
//   4. Slot model never acks -> after 4 WAIT_ACK cycles ack_err=1, shots_fired unchanged,
//      COOLDOWN still entered; ack_err stays 1 until rst.
//   5. ship_dead asserted in WAIT_ACK and in COOLDOWN -> IDLE next cycle, slot_fire=0,
//      pending cleared; edges while ship_dead=1 produce no pulse.
//   6. Hold fire_btn 60 cycles: without AUTOFIRE_EN 1 launch; with AUTOFIRE_EN 4 launches;
//      plus shots_fired preset near 16'hFFFF saturates, does not wrap.

Source files
------------

// File: rtl/missile_pkg.sv
// Shared types and constants for the missile subsystem.
// Used by the fire scheduler and the per-slot missile controllers.
package missile_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_ACK = 2'd2,
        S_COOLDOWN = 2'd3
    } fire_state_e;

    localparam int unsigned NUM_SLOTS_DEF   = 3;
    localparam int unsigned COOLDOWN_DEF    = 2000000;
    localparam int unsigned ACK_TIMEOUT_DEF = 4;
    localparam int unsigned CNT_W_DEF       = 22;

    // Geometry used by the slot controllers when drawing a missile.
    localparam int unsigned MISSILE_W   = 2;
    localparam int unsigned MISSILE_H   = 8;
    localparam int unsigned SHIP_TOP_Y  = 440;
    localparam int unsigned MISSILE_DY  = 4;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        logic [7:0] m;
        m = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/missile_fire_sched_pick.sv
// Lowest-index free slot encoder for the missile fire scheduler.
// Combinational: sel is only meaningful when any_free is high.
module missile_slot_pick #(
    parameter int unsigned NUM_SLOTS = 3
) (
    input  logic [NUM_SLOTS-1:0] slot_on,
    output logic [2:0]           sel,
    output logic                 any_free
);

    always_comb begin
        sel      = '0;
        any_free = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_on[i]) begin
                sel      = 3'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/missile_fire_sched.sv
// Fire scheduler: shares missile controllers between fire requests.
// Define AUTOFIRE_EN to let a held fire button re-arm requests while idle.
module missile_fire_sched
    import missile_pkg::*;
#(
    parameter int unsigned NUM_SLOTS       = NUM_SLOTS_DEF,
    parameter int unsigned COOLDOWN_CYCLES = COOLDOWN_DEF,
    parameter int unsigned ACK_TIMEOUT     = ACK_TIMEOUT_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic                 fire_btn,
    input  logic                 ship_dead,
    input  logic [NUM_SLOTS-1:0] slot_on,
    output logic [NUM_SLOTS-1:0] slot_fire,
    output logic                 all_busy,
    output logic                 cooldown,
    output logic [15:0]          shots_fired,
    output logic                 ack_err
);

    localparam int unsigned ACK_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CD_LOAD  = CNT_W'(COOLDOWN_CYCLES - 1);

    fire_state_e      state;
    fire_state_e      state_nxt;
    logic             pending;
    logic             btn_prev;
    logic [2:0]       sel;
    logic [ACK_W-1:0] ack_cnt;
    logic [CNT_W-1:0] cd_cnt;

    logic [2:0] pick_sel;
    logic       any_free;
    logic [7:0] on_x;
    logic [7:0] fire_x;
    logic       btn_edge;
    logic       lvl_set;
    logic       req_set;
    logic       go;
    logic       ack_hit;
    logic       ack_to;
    logic       cd_done;
    logic       enter_cd;

    missile_slot_pick #(
        .NUM_SLOTS(NUM_SLOTS)
    ) u_pick (
        .slot_on (slot_on),
        .sel     (pick_sel),
        .any_free(any_free)
    );

    assign on_x     = 8'(slot_on);
    assign fire_x   = onehot8(sel);
    assign btn_edge = fire_btn & ~btn_prev;

    always_ff @(posedge pclk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (ship_dead) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:     if (go) state_nxt = S_ISSUE;
                S_ISSUE:    state_nxt = S_WAIT_ACK;
                S_WAIT_ACK: if (ack_hit || ack_to) state_nxt = S_COOLDOWN;
                S_COOLDOWN: if (cd_done) state_nxt = S_IDLE;
                default:    state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        go       = 1'b0;
        ack_hit  = 1'b0;
        ack_to   = 1'b0;
        cd_done  = 1'b0;
        unique case (state)
            S_IDLE:     go = pending & any_free;
            S_WAIT_ACK: begin
                ack_hit = on_x[sel];
                ack_to  = ~on_x[sel] & (ack_cnt == ACK_LAST);
            end
            S_COOLDOWN: cd_done = (cd_cnt == '0);
            default:    go = 1'b0;
        endcase
        enter_cd = (state != S_COOLDOWN) & (state_nxt == S_COOLDOWN);
    end

`ifdef AUTOFIRE_EN
    // A held button re-arms only while idle and not already launching.
    assign lvl_set = fire_btn & (state == S_IDLE) & ~go;
`else
    assign lvl_set = 1'b0;
`endif
    assign req_set = btn_edge | lvl_set;

    always_ff @(posedge pclk) begin
        if (rst) begin
            pending     <= 1'b0;
            btn_prev    <= 1'b0;
            sel         <= '0;
            ack_cnt     <= '0;
            cd_cnt      <= '0;
            slot_fire   <= '0;
            all_busy    <= 1'b0;
            cooldown    <= 1'b0;
            shots_fired <= '0;
            ack_err     <= 1'b0;
        end else begin
            btn_prev  <= fire_btn;
            all_busy  <= &slot_on;
            cooldown  <= (state_nxt == S_COOLDOWN);
            slot_fire <= '0;
            if (ship_dead) begin
                pending <= 1'b0;
                ack_cnt <= '0;
                cd_cnt  <= '0;
            end else begin
                // A new request in the issuing cycle queues the next shot.
                if (req_set)  pending <= 1'b1;
                else if (go)  pending <= 1'b0;
                if (go) sel <= pick_sel;
                if (state == S_ISSUE) begin
                    slot_fire <= fire_x[NUM_SLOTS-1:0];
                    ack_cnt   <= '0;
                end
                if (state == S_WAIT_ACK && !ack_hit && !ack_to)
                    ack_cnt <= ack_cnt + 1'b1;
                if (ack_hit && shots_fired != 16'hFFFF)
                    shots_fired <= shots_fired + 16'd1;
                if (ack_to) ack_err <= 1'b1;
                if (enter_cd)
                    cd_cnt <= CD_LOAD;
                else if (state == S_COOLDOWN && !cd_done)
                    cd_cnt <= cd_cnt - 1'b1;
            end
        end
    end

endmodule
